// File: rtl/fft_frame_ctrl.sv
// Frames an upstream sample stream into N-point bursts for an SDF FFT and tags its results.
// Error flags are built only when FFT_FRAME_CTRL_ERR_EN is defined; otherwise they read 0.
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 4
`endif
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

module fft_frame_ctrl #(
    parameter int unsigned N_LOG2       = `C2LOG_FFT_POINTS,
    parameter int unsigned DW           = `DATA_IN_WIDTH,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_re,
    input  logic [DW-1:0]     s_im,
    input  logic              s_last,
    output logic              fft_di_en,
    output logic [DW-1:0]     fft_di_re,
    output logic [DW-1:0]     fft_di_im,
    input  logic              fft_do_en,
    input  logic [DW-1:0]     fft_do_re,
    input  logic [DW-1:0]     fft_do_im,
    output logic              m_valid,
    output logic [DW-1:0]     m_re,
    output logic [DW-1:0]     m_im,
    output logic              m_sof,
    output logic              m_eof,
    output logic [N_LOG2-1:0] m_bin,
    output logic              busy,
    output logic              err_underrun,
    output logic              err_framing,
    output logic              err_orphan,
    input  logic              err_clr
);
    typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

    localparam logic [N_LOG2-1:0] LAST   = {N_LOG2{1'b1}};
    localparam logic [4:0]        MAX_IF = 5'(MAX_INFLIGHT);

    state_t            state;
    logic [N_LOG2-1:0] icnt;
    logic [N_LOG2-1:0] ocnt;
    logic [N_LOG2-1:0] ocnt_rev;
    logic [3:0]        inflight;
    logic              accept, gap, frame_start, more_ok, eof_hit, orphan_hit;

    assign accept      = (state == RUN) && s_valid;
    assign gap         = (state == RUN) && !s_valid && (icnt != '0);
    assign frame_start = accept && (icnt == '0);
    // Back-to-back continuation needs room for one more frame beyond those counted.
    assign more_ok     = enable && (({1'b0, inflight} + 5'd1) < MAX_IF);
    assign eof_hit     = fft_do_en && (ocnt == LAST) && (inflight != '0);
    assign orphan_hit  = fft_do_en && (inflight == '0);
    assign ocnt_rev    = {<<{ocnt}};
    assign busy        = (state != IDLE) || (inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            icnt      <= '0;
            s_ready   <= 1'b0;
            fft_di_en <= 1'b0;
            fft_di_re <= '0;
            fft_di_im <= '0;
        end else begin
            fft_di_en <= 1'b0;
            fft_di_re <= '0;
            fft_di_im <= '0;
            unique case (state)
                IDLE: begin
                    if (enable && ({1'b0, inflight} < MAX_IF)) begin
                        state   <= RUN;
                        s_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        fft_di_en <= 1'b1;
                        fft_di_re <= s_re;
                        fft_di_im <= s_im;
                        icnt      <= icnt + 1'b1;
                        if (icnt == LAST && !more_ok) begin
                            state   <= IDLE;
                            s_ready <= 1'b0;
                        end
                    end else if (icnt != '0) begin
                        // Missing beat mid-frame becomes a zero point.
                        fft_di_en <= 1'b1;
                        icnt      <= icnt + 1'b1;
                        if (icnt == LAST) begin
                            if (!more_ok) begin
                                state   <= IDLE;
                                s_ready <= 1'b0;
                            end
                        end else begin
                            state   <= PAD;
                            s_ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    fft_di_en <= 1'b1;
                    icnt      <= icnt + 1'b1;
                    if (icnt == LAST) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_re     <= '0;
            m_im     <= '0;
            m_sof    <= 1'b0;
            m_eof    <= 1'b0;
            m_bin    <= '0;
            ocnt     <= '0;
            inflight <= '0;
        end else begin
            m_valid <= fft_do_en;
            m_re    <= fft_do_re;
            m_im    <= fft_do_im;
            m_sof   <= fft_do_en && (ocnt == '0);
            m_eof   <= fft_do_en && (ocnt == LAST);
            m_bin   <= fft_do_en ? ocnt_rev : '0;
            if (fft_do_en) ocnt <= ocnt + 1'b1;
            if (frame_start && !eof_hit) begin
                inflight <= inflight + 4'd1;
            end else if (!frame_start && eof_hit) begin
                inflight <= inflight - 4'd1;
            end
        end
    end

`ifdef FFT_FRAME_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underrun <= 1'b0;
            err_framing  <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            err_underrun <= (err_underrun && !err_clr) || gap;
            err_framing  <= (err_framing && !err_clr) || (accept && (s_last != (icnt == LAST)));
            err_orphan   <= (err_orphan && !err_clr) || orphan_hit;
        end
    end
`else
    logic unused_err;
    assign unused_err   = ^{err_clr, s_last, gap, orphan_hit};
    assign err_underrun = 1'b0;
    assign err_framing  = 1'b0;
    assign err_orphan   = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed phases plus random traffic against a frame-level model,
// with a 40-cycle delay line standing in for the FFT pipeline.
module tb_fft_frame_ctrl;
    localparam int NL   = 4;
    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int MAXF = 2;
    localparam int LAT  = 40;
`ifdef FFT_FRAME_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, enable, s_valid, s_ready, s_last, err_clr;
    logic [DW-1:0] s_re, s_im, fft_di_re, fft_di_im, fft_do_re, fft_do_im, m_re, m_im;
    logic fft_di_en, fft_do_en, m_valid, m_sof, m_eof, busy;
    logic [NL-1:0] m_bin;
    logic err_underrun, err_framing, err_orphan;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N_LOG2(NL), .DW(DW), .MAX_INFLIGHT(MAXF)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
        .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_sof(m_sof), .m_eof(m_eof),
        .m_bin(m_bin), .busy(busy), .err_underrun(err_underrun), .err_framing(err_framing),
        .err_orphan(err_orphan), .err_clr(err_clr)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Frame-level model: taking = accepting input, filling = zero padding, pts = points of frame.
    bit taking, filling, took, force_do;
    int pts, infl, ocnt;
    bit x_di_en, x_valid, x_sof, x_eof, x_un, x_fr, x_or;
    logic [DW-1:0] x_di_re, x_di_im, x_re, x_im;
    int x_bin;
    int bin_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [2*DW:0] pipe [LAT];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_next();
        bit issue, eof_hit, set_un, set_fr, set_or;
        issue = 0; set_un = 0; set_fr = 0; set_or = 0; took = 0;
        x_di_en = 0; x_di_re = '0; x_di_im = '0;
        if (rst) begin
            taking = 0; filling = 0; pts = 0; infl = 0; ocnt = 0;
            x_valid = 0; x_re = '0; x_im = '0; x_sof = 0; x_eof = 0; x_bin = 0;
            x_un = 0; x_fr = 0; x_or = 0;
            return;
        end
        if (taking) begin
            if (s_valid || pts != 0) begin
                x_di_en = 1;
                if (s_valid) begin
                    took = 1; x_di_re = s_re; x_di_im = s_im;
                    set_fr = (s_last != (pts == N - 1));
                end else begin
                    set_un = 1;
                end
                issue = (pts == 0);
                if (pts == N - 1) taking = enable && (infl + 1 < MAXF);
                else if (!s_valid) begin taking = 0; filling = 1; end
                pts = (pts + 1) % N;
            end
        end else if (filling) begin
            x_di_en = 1;
            if (pts == N - 1) filling = 0;
            pts = (pts + 1) % N;
        end else if (enable && infl < MAXF) begin
            taking = 1;
        end
        x_valid = fft_do_en; x_re = fft_do_re; x_im = fft_do_im;
        x_sof = fft_do_en && ocnt == 0;
        x_eof = fft_do_en && ocnt == N - 1;
        x_bin = fft_do_en ? bin_tab[ocnt] : 0;
        set_or = fft_do_en && infl == 0;
        eof_hit = x_eof && infl != 0;
        infl = infl + int'(issue) - int'(eof_hit);
        if (fft_do_en) ocnt = (ocnt + 1) % N;
        x_un = (x_un && !err_clr) || set_un;
        x_fr = (x_fr && !err_clr) || set_fr;
        x_or = (x_or && !err_clr) || set_or;
    endtask

    task automatic step();
        model_next();
        @(posedge clk); #1;
        chk("s_ready", 32'(s_ready), 32'(taking));
        chk("fft_di_en", 32'(fft_di_en), 32'(x_di_en));
        if (x_di_en || rst) begin
            chk("fft_di_re", 32'(fft_di_re), 32'(x_di_re));
            chk("fft_di_im", 32'(fft_di_im), 32'(x_di_im));
        end
        chk("m_valid", 32'(m_valid), 32'(x_valid));
        chk("m_re", 32'(m_re), 32'(x_re));
        chk("m_im", 32'(m_im), 32'(x_im));
        chk("m_sof", 32'(m_sof), 32'(x_sof));
        chk("m_eof", 32'(m_eof), 32'(x_eof));
        if (x_valid || rst) chk("m_bin", 32'(m_bin), 32'(x_bin));
        chk("busy", 32'(busy), 32'(taking || filling || infl != 0));
        chk("err_underrun", 32'(err_underrun), 32'(ERR_EN && x_un));
        chk("err_framing", 32'(err_framing), 32'(ERR_EN && x_fr));
        chk("err_orphan", 32'(err_orphan), 32'(ERR_EN && x_or));
        if (rst) for (int i = 0; i < LAT; i++) pipe[i] = '0;
        {fft_do_en, fft_do_re, fft_do_im} = pipe[LAT-1];
        if (force_do) begin
            fft_do_en = 1'b1; fft_do_re = DW'($urandom); fft_do_im = DW'($urandom);
        end
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {fft_di_en, fft_di_re ^ 16'h3c3c, fft_di_im + 16'd7};
    endtask

    task automatic idle(input int cycles);
        s_valid = 0; s_last = 0;
        repeat (cycles) step();
    endtask

    // Offers beats until 'beats' are accepted; bad_at marks a point index with a wrong s_last.
    task automatic feed(input int beats, input int bad_at);
        int got = 0;
        int guard = 0;
        while (got < beats && guard < 2000) begin
            s_valid = 1; s_re = DW'($urandom); s_im = DW'($urandom);
            s_last = (pts == N - 1) ^ (pts == bad_at);
            step();
            if (took) got++;
            guard++;
        end
        if (got < beats) begin
            n_vec++; n_bad++;
            $error("FAIL feed_timeout: observed %0d beats expected %0d", got, beats);
        end
        s_valid = 0; s_last = 0;
    endtask

    initial begin
        rst = 1; enable = 0; s_valid = 0; s_last = 0; s_re = '0; s_im = '0; err_clr = 0;
        fft_do_en = 0; fft_do_re = '0; fft_do_im = '0; force_do = 0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        repeat (2) step();
        rst = 0;
        // Clean frame and its tagged output frame.
        enable = 1;
        feed(16, -1);
        idle(70);
        // Mid-frame stall after beat 5, then a following frame from point 0.
        feed(6, -1);
        idle(14);
        feed(16, -1);
        idle(5);
        err_clr = 1; step(); err_clr = 0;
        idle(60);
        // Early s_last on beat 7, then clear.
        feed(16, 7);
        idle(3);
        err_clr = 1; step(); err_clr = 0;
        idle(60);
        // Continuous input throttled by the in-flight limit.
        feed(96, -1);
        idle(80);
        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            s_valid = $urandom_range(0, 9) < 8;
            s_re = DW'($urandom); s_im = DW'($urandom);
            s_last = (pts == N - 1) ^ ($urandom_range(0, 19) == 0);
            enable = $urandom_range(0, 29) != 0;
            err_clr = $urandom_range(0, 24) == 0;
            step();
        end
        err_clr = 0; enable = 0;
        idle(100);
        // Output beat with nothing in flight.
        force_do = 1; step(); force_do = 0;
        idle(3);
        // Reset while beat 9 is presented.
        rst = 1; step(); rst = 0;
        enable = 1;
        feed(9, -1);
        s_valid = 1; s_re = DW'($urandom); s_im = DW'($urandom); rst = 1;
        step();
        rst = 0; s_valid = 0; enable = 0;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default `C2LOG_FFT_POINTS, meaning log2 of the frame length N.
REQ-002 SHALL have parameter DW, default `DATA_IN_WIDTH, meaning the sample component width.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of frames issued but not yet fully output (range 1..15).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: enable  in  1  allows new frames to start.
REQ-007 SHALL have ports: s_valid  in  1 / s_ready  out  1 / s_re, s_im  in  DW / s_last  in  1  upstream sample stream.
REQ-008 SHALL have ports: fft_di_en  out  1 / fft_di_re, fft_di_im  out  DW  drive into the SDF pipeline.
REQ-009 SHALL have ports: fft_do_en  in  1 / fft_do_re, fft_do_im  in  DW  results from the SDF pipeline.
REQ-010 SHALL have ports: m_valid  out  1 / m_re, m_im  out  DW / m_sof, m_eof  out  1 / m_bin  out  N_LOG2  tagged result stream (no backpressure).
REQ-011 SHALL have ports: busy  out  1 / err_underrun, err_framing, err_orphan  out  1 / err_clr  in  1.

Function
REQ-012 SHALL implement the FSM IDLE, RUN, PAD, with an input point counter icnt of N_LOG2 bits.
REQ-013 IDLE: s_ready=0, fft_di_en=0; go to RUN when enable=1 and inflight<MAX_INFLIGHT.
REQ-014 RUN: s_ready=1; each s_valid&s_ready beat registers s_re/s_im onto fft_di_re/im with fft_di_en=1 one cycle later, and increments icnt.
REQ-015 RUN, s_valid=0 with icnt!=0 (mid-frame gap): go to PAD that cycle; the cycle's fft_di_en=1 with zero data, counted as a point, and err_underrun is set.
REQ-016 RUN, s_valid=0 with icnt==0: stay in RUN, fft_di_en=0, no error.
REQ-017 PAD: s_ready=0; drive zero samples with fft_di_en=1 until icnt wraps to 0, then go to IDLE; a frame therefore always presents exactly N contiguous fft_di_en cycles.
REQ-018 On the beat where icnt==N-1: frame complete; remain in RUN only if enable=1 and inflight+1<MAX_INFLIGHT, else go to IDLE; back-to-back frames SHALL have no gap in fft_di_en.
REQ-019 s_last SHALL be checked only on accepted beats; s_last=1 at icnt!=N-1, or s_last=0 at icnt==N-1, sets err_framing; data flow is unchanged.
REQ-020 inflight SHALL increment on issue of the first point of a frame and decrement when m_eof is asserted; simultaneous increment and decrement leave it unchanged.
REQ-021 Output side: m_valid, m_re, m_im SHALL be fft_do_en, fft_do_re, fft_do_im registered once, i.e. one cycle of latency.
REQ-022 ocnt (N_LOG2 bits) SHALL count m_valid beats; m_sof=1 when ocnt==0 and m_eof=1 when ocnt==N-1, both only while m_valid=1.
REQ-023 m_bin SHALL equal bit-reverse(ocnt), giving the natural-order bin index of the DIF output.
REQ-024 fft_do_en=1 while inflight==0 SHALL set err_orphan, output the data anyway, and leave inflight at 0.
REQ-025 busy SHALL be 1 when the state is not IDLE or inflight!=0.
REQ-026 Error flags SHALL be sticky until err_clr=1; a set and a clear in the same cycle SHALL leave the flag set.
REQ-027 If enable falls mid-frame, the current frame SHALL complete in RUN/PAD before the FSM enters IDLE.

Reset
REQ-028 While rst=1: state=IDLE, icnt=ocnt=inflight=0, and s_ready, fft_di_en, fft_di_re/im, m_valid, m_re/im, m_sof, m_eof, m_bin, busy and all err flags =0.
REQ-029 A reset mid-frame SHALL abandon the frame immediately; the pipeline flush is the system's responsibility.

Configuration
REQ-030 With macro FFT_FRAME_CTRL_ERR_EN defined, err_underrun, err_framing, err_orphan and err_clr SHALL be implemented as specified.
REQ-031 Without FFT_FRAME_CTRL_ERR_EN, all err_* outputs SHALL be tied 0, and PAD/zero-fill and the inflight clamp SHALL still function.

Verification
REQ-032 N=16, 16 contiguous beats with s_last on beat 15 -> fft_di_en high for 16 cycles starting 1 cycle after the first beat, no errors.
REQ-033 Stall s_valid after beat 5 -> 10 zero samples padded, err_underrun=1, s_ready=0 until IDLE, next frame starts at icnt=0.
REQ-034 s_last asserted on beat 7 -> err_framing=1, frame still 16 points; err_clr pulse -> flag returns to 0.
REQ-035 MAX_INFLIGHT=2, pipeline model with latency 40, continuous input -> s_ready drops after frame 2 and resumes one cycle after the first m_eof.
REQ-036 Output frame of 16 beats -> m_sof on beat 0, m_eof on beat 15, m_bin sequence 0,8,4,12,2,...,15.
REQ-037 rst asserted at beat 9 -> all outputs 0 the next cycle, inflight=0, busy=0.
